// File: rtl/data_slot_sequencer.sv
// Write sequencer for a level-sensitive slot bank: each accepted sample is
// presented with a stable index and data around a single-cycle write strobe.
module data_slot_sequencer #(
  parameter int unsigned SLOTS  = 64,
  parameter int unsigned DATA_W = 11,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              frame_start,
  input  logic              clear_err,
  output logic [IDX_W-1:0]  slot_idx,
  output logic [DATA_W-1:0] slot_data,
  output logic              slot_we,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  localparam logic [3:0]       SETTLE_M1 = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLOTS - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic [7:0]          count_q, count_d;
  logic                err_q, err_d;
  logic                exit_w;
  logic                set_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    count_d = count_q;
    err_d   = err_q;
    exit_w  = 1'b0;
    set_err = 1'b0;

    case (state_q)
      IDLE: begin
        // Restart is applied before any same-cycle transfer, so that sample lands in slot 0.
        if (frame_start) begin
          idx_d = '0;
          if (idx_q != '0) set_err = 1'b1;
        end
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = SETTLE_M1;
          state_d = (SETTLE == 0) ? STROBE : SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = STROBE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      STROBE: begin
        if (SETTLE == 0) begin
          exit_w = 1'b1;
        end else begin
          cnt_d   = SETTLE_M1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) exit_w = 1'b1;
        else             cnt_d  = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && frame_start) pend_d = 1'b1;

    // A restart requested mid-write takes effect here, after the strobe at the original index.
    if (exit_w) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        done_d  = 1'b1;
        count_d = count_q + 8'd1;
      end else if (pend_q || frame_start) begin
        idx_d   = '0;
        set_err = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (set_err)        err_d = 1'b1;
    else if (clear_err) err_d = 1'b0;
  end

  assign in_ready    = (state_q == IDLE);
  assign slot_we     = (state_q == STROBE);
  assign busy        = (state_q != IDLE);
  assign slot_idx    = idx_q;
  assign slot_data   = data_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_data_slot_sequencer.sv
// Directed bench for data_slot_sequencer: SETTLE=2 instance for the main
// sequence, SETTLE=0 instance for back-to-back streaming.
module tb_data_slot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] in_data = '0;
  logic        in_valid = 1'b0, frame_start = 1'b0, clear_err = 1'b0;
  logic        in_ready, slot_we, frame_done, frame_err, busy;
  logic [5:0]  slot_idx;
  logic [10:0] slot_data;
  logic [7:0]  frame_count;

  logic [10:0] in_data0 = '0;
  logic        in_valid0 = 1'b0, frame_start0 = 1'b0, clear_err0 = 1'b0;
  logic        in_ready0, slot_we0, frame_done0, frame_err0, busy0;
  logic [5:0]  slot_idx0;
  logic [10:0] slot_data0;
  logic [7:0]  frame_count0;

  data_slot_sequencer #(.SLOTS(64), .DATA_W(11), .IDX_W(6), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .frame_start(frame_start), .clear_err(clear_err), .slot_idx(slot_idx),
    .slot_data(slot_data), .slot_we(slot_we), .frame_done(frame_done),
    .frame_count(frame_count), .frame_err(frame_err), .busy(busy)
  );

  data_slot_sequencer #(.SLOTS(64), .DATA_W(11), .IDX_W(6), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .frame_start(frame_start0), .clear_err(clear_err0), .slot_idx(slot_idx0),
    .slot_data(slot_data0), .slot_we(slot_we0), .frame_done(frame_done0),
    .frame_count(frame_count0), .frame_err(frame_err0), .busy(busy0)
  );

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done0_seen = 0;
  logic [16:0] q[$];
  logic [16:0] q0[$];
  logic [5:0]  exp_idx = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [10:0] d, input logic fs);
    frame_start = fs;
    if (fs) exp_idx = '0;
    in_data  = d;
    in_valid = 1'b1;
    q.push_back({exp_idx, d});
    exp_idx = exp_idx + 6'd1;
    tick();
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk(tag, in_ready, 1);
  endtask

  // Scoreboards: every strobe must match the oldest expected (idx, data).
  always @(negedge clk) begin
    if (!rst && slot_we) begin
      logic [16:0] e;
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL strobe_unexpected observed=%0h expected=none", {slot_idx, slot_data});
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        total++;
        assert ({slot_idx, slot_data} === e) else begin
          bad++;
          $error("FAIL strobe observed=%0h expected=%0h", {slot_idx, slot_data}, e);
        end
      end
    end
    if (!rst && frame_done) done_seen++;
  end

  always @(negedge clk) begin
    if (!rst && slot_we0) begin
      logic [16:0] e;
      total++;
      assert (q0.size() != 0) else begin
        bad++;
        $error("FAIL z_strobe_unexpected observed=%0h expected=none", {slot_idx0, slot_data0});
      end
      if (q0.size() != 0) begin
        e = q0.pop_front();
        total++;
        assert ({slot_idx0, slot_data0} === e) else begin
          bad++;
          $error("FAIL z_strobe observed=%0h expected=%0h", {slot_idx0, slot_data0}, e);
        end
      end
    end
    if (!rst && frame_done0) done0_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [5:0] m_idx0;

    // Reset values
    #2;
    chk("rst_idx", slot_idx, 0);
    chk("rst_data", slot_data, 0);
    chk("rst_we", slot_we, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_done", frame_done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write, SETTLE=2
    send(11'h5A3, 1'b0);
    chk("sw_t1_we", slot_we, 0);
    chk("sw_t1_busy", busy, 1);
    chk("sw_t1_ready", in_ready, 0);
    chk("sw_t1_idx", slot_idx, 0);
    chk("sw_t1_data", slot_data, 11'h5A3);
    tick();
    chk("sw_t2_we", slot_we, 0);
    tick();
    chk("sw_t3_we", slot_we, 1);
    chk("sw_t3_idx", slot_idx, 0);
    tick();
    chk("sw_t4_we", slot_we, 0);
    tick();
    chk("sw_t5_we", slot_we, 0);
    chk("sw_t5_ready", in_ready, 0);
    chk("sw_t5_idx", slot_idx, 0);
    chk("sw_t5_data", slot_data, 11'h5A3);
    tick();
    chk("sw_t6_ready", in_ready, 1);
    chk("sw_t6_idx", slot_idx, 1);
    chk("sw_t6_data", slot_data, 11'h5A3);

    // Reset during strobe
    send(11'h123, 1'b0);
    tick();
    tick();
    chk("mr_we_before", slot_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_we_async", slot_we, 0);
    chk("mr_ready_async", in_ready, 1);
    chk("mr_busy_async", busy, 0);
    q.delete();
    exp_idx = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mr_idx", slot_idx, 0);
    chk("mr_data", slot_data, 0);
    chk("mr_count", frame_count, 0);
    chk("mr_ready", in_ready, 1);

    // Full frame of 64 samples
    done_seen = 0;
    for (int k = 0; k < 64; k++) begin
      wait_ready("ff_ready");
      send(11'(k), 1'b0);
    end
    wait_ready("ff_last_ready");
    chk("ff_done", frame_done, 1);
    chk("ff_idx", slot_idx, 0);
    chk("ff_count", frame_count, 1);
    chk("ff_q_empty", q.size(), 0);
    tick();
    chk("ff_done_one_cycle", frame_done, 0);
    chk("ff_done_pulses", done_seen, 1);

    // Short frame restarted from IDLE
    for (int k = 0; k < 10; k++) begin
      wait_ready("sf_ready");
      send(11'h100 + 11'(k), 1'b0);
    end
    wait_ready("sf_last_ready");
    chk("sf_idx10", slot_idx, 10);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_idx = '0;
    chk("sf_idx0", slot_idx, 0);
    chk("sf_err", frame_err, 1);
    chk("sf_count", frame_count, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("sf_cleared", frame_err, 0);

    // Set beats clear when they coincide
    send(11'h2AA, 1'b0);
    wait_ready("sw_ready");
    chk("sw_idx1", slot_idx, 1);
    frame_start = 1'b1;
    clear_err   = 1'b1;
    tick();
    frame_start = 1'b0;
    clear_err   = 1'b0;
    exp_idx = '0;
    chk("set_wins_err", frame_err, 1);
    chk("set_wins_idx", slot_idx, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("set_wins_cleared", frame_err, 0);

    // Restart and transfer in the same IDLE cycle: sample goes to slot 0
    send(11'h3CC, 1'b0);
    wait_ready("rt_ready0");
    send(11'h155, 1'b1);
    wait_ready("rt_ready1");
    chk("rt_idx", slot_idx, 1);
    chk("rt_err", frame_err, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

    // frame_start during SETUP of a write to slot 5; in_valid while busy ignored
    for (int k = 0; k < 4; k++) begin
      wait_ready("bs_ready");
      send(11'h040 + 11'(k), 1'b0);
    end
    wait_ready("bs_ready5");
    chk("bs_idx5", slot_idx, 5);
    chk("bs_err_clear", frame_err, 0);
    send(11'h7E5, 1'b0);
    in_valid    = 1'b1;
    in_data     = 11'h7FF;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("bs_idx_hold", slot_idx, 5);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    wait_ready("bs_exit_ready");
    exp_idx = '0;
    chk("bs_idx0", slot_idx, 0);
    chk("bs_err", frame_err, 1);
    chk("bs_count", frame_count, 1);
    chk("bs_no_done", frame_done, 0);
    chk("bs_done_pulses", done_seen, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    send(11'h0AB, 1'b0);
    wait_ready("bs_after_ready");
    chk("bs_after_idx", slot_idx, 1);
    chk("bs_q_empty", q.size(), 0);

    // SETTLE=0: continuous in_valid, one accept every two cycles
    acc = 0;
    m_idx0 = '0;
    in_valid0 = 1'b1;
    for (int c = 0; c < 132; c++) begin
      chk("z_ready", in_ready0, (c % 2 == 0));
      chk("z_we", slot_we0, (c % 2 == 1));
      chk("z_done", frame_done0, (c == 128));
      if (c % 2 == 0) begin
        in_data0 = acc[10:0];
        q0.push_back({m_idx0, acc[10:0]});
        m_idx0 = m_idx0 + 6'd1;
        acc++;
      end else begin
        in_data0 = 11'h7FF;
      end
      tick();
    end
    in_valid0 = 1'b0;
    chk("z_q_empty", q0.size(), 0);
    chk("z_done_pulses", done0_seen, 1);
    chk("z_count", frame_count0, 1);
    chk("z_idx", slot_idx0, 2);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
